// File: rtl/msc_pkg.sv
// Shared definitions for the multi-port cache/prefetch controller:
// control and status bit positions, the command type and the address-width helper.
package msc_pkg;

  localparam int unsigned CTRL_RESET    = 0;
  localparam int unsigned CTRL_FLUSH    = 1;
  localparam int unsigned CTRL_PREFETCH = 2;
  localparam int unsigned CTRL_ENABLE   = 3;

  localparam int unsigned STAT_ENABLE   = 0;
  localparam int unsigned STAT_ACTIVE   = 1;
  localparam int unsigned STAT_PEND_RST = 2;
  localparam int unsigned STAT_PEND_FL  = 3;
  localparam int unsigned STAT_PEND_PF  = 4;
  localparam int unsigned STAT_W        = 5;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_RESET,
    CMD_FLUSH,
    CMD_PREFETCH
  } cmd_e;

  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(2 * n);
  endfunction

endpackage

// File: rtl/msc_multi_if.sv
// Register bus and per-port command/handshake signals of msc_multi.
interface msc_multi_if
  import msc_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PAGE_W    = 8,
  parameter int DATA_W    = 16
);
  localparam int ADDR_W = addr_w(NUM_PORTS);

  logic                        wren;
  logic [ADDR_W-1:0]           A;
  logic [DATA_W-1:0]           data;
  logic [DATA_W-1:0]           rdata;
  logic [NUM_PORTS*PAGE_W-1:0] page;
  logic [NUM_PORTS-1:0]        port_reset;
  logic [NUM_PORTS-1:0]        port_flush;
  logic [NUM_PORTS-1:0]        port_prefetch;
  logic [NUM_PORTS-1:0]        port_req;
  logic [NUM_PORTS-1:0]        port_ready;

  modport master (
    output wren, A, data, port_req, port_ready,
    input  rdata, page, port_reset, port_flush, port_prefetch
  );

  modport slave (
    input  wren, A, data, port_req, port_ready,
    output rdata, page, port_reset, port_flush, port_prefetch
  );
endinterface

// File: rtl/msc_port_ctrl.sv
// One port: enable/page registers, pending command flags, active tracking and
// prioritised strobe issue. Status output exists only with MSC_STATUS_READ_EN.
module msc_port_ctrl
  import msc_pkg::*;
#(
  parameter int PAGE_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_we_i,
  input  logic              page_we_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              req_i,
  input  logic              ready_i,
  output logic [PAGE_W-1:0] page_o,
  output logic              reset_o,
  output logic              flush_o,
  output logic              prefetch_o
`ifdef MSC_STATUS_READ_EN
  ,
  output logic [STAT_W-1:0] status_o
`endif
);

  logic              enable_q, enable_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic              active_q, active_d;
  logic              prev_req_q, prev_ready_q;
  logic              pend_rst_q, pend_rst_d;
  logic              pend_fl_q, pend_fl_d;
  logic              pend_pf_q, pend_pf_d;

  logic rise_req, fall_rdy, idle, cmd_ok;
  cmd_e issue;
  logic unused_data;

  assign unused_data = ^data_i;

  always_comb begin
    rise_req = req_i & ~prev_req_q;
    fall_rdy = ~ready_i & prev_ready_q;
    idle     = ~(active_q | req_i) | fall_rdy;
    cmd_ok   = ctrl_we_i & enable_q;

    issue = CMD_NONE;
    if (idle) begin
      if (pend_rst_q)     issue = CMD_RESET;
      else if (pend_fl_q) issue = CMD_FLUSH;
      else if (pend_pf_q) issue = CMD_PREFETCH;
    end

    enable_d = ctrl_we_i ? data_i[CTRL_ENABLE] : enable_q;
    page_d   = (page_we_i & enable_q) ? data_i[PAGE_W-1:0] : page_q;
    active_d = fall_rdy ? 1'b0 : (rise_req ? 1'b1 : active_q);

    // A new write setting a flag overrides its clear by issue in the same cycle.
    pend_rst_d = (cmd_ok & data_i[CTRL_RESET]) | (pend_rst_q & (issue != CMD_RESET));
    pend_fl_d  = (cmd_ok & data_i[CTRL_FLUSH]) |
                 (pend_fl_q & (issue != CMD_FLUSH) & (issue != CMD_RESET));
    pend_pf_d  = (cmd_ok & data_i[CTRL_PREFETCH]) |
                 (pend_pf_q & (issue != CMD_PREFETCH) & (issue != CMD_RESET));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q     <= 1'b0;
      page_q       <= '0;
      active_q     <= 1'b0;
      prev_req_q   <= 1'b0;
      prev_ready_q <= 1'b1;
      pend_rst_q   <= 1'b1;
      pend_fl_q    <= 1'b0;
      pend_pf_q    <= 1'b0;
    end else begin
      enable_q     <= enable_d;
      page_q       <= page_d;
      active_q     <= active_d;
      prev_req_q   <= req_i;
      prev_ready_q <= ready_i;
      pend_rst_q   <= pend_rst_d;
      pend_fl_q    <= pend_fl_d;
      pend_pf_q    <= pend_pf_d;
    end
  end

  assign page_o     = page_q;
  assign reset_o    = rst | (issue == CMD_RESET);
  assign flush_o    = (issue == CMD_FLUSH);
  assign prefetch_o = (issue == CMD_PREFETCH);

`ifdef MSC_STATUS_READ_EN
  always_comb begin
    status_o                = '0;
    status_o[STAT_ENABLE]   = enable_q;
    status_o[STAT_ACTIVE]   = active_q;
    status_o[STAT_PEND_RST] = pend_rst_q;
    status_o[STAT_PEND_FL]  = pend_fl_q;
    status_o[STAT_PEND_PF]  = pend_pf_q;
  end
`endif

endmodule

// File: rtl/msc_multi.sv
// Multi-port cache/prefetch command controller: address decode, per-port
// instances and optional status readback (macro MSC_STATUS_READ_EN).
module msc_multi
  import msc_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PAGE_W    = 8,
  parameter int DATA_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  msc_multi_if.slave  bus
);
  localparam int ADDR_W = addr_w(NUM_PORTS);

  logic [PAGE_W-1:0] page_a  [NUM_PORTS];
  logic              rst_a   [NUM_PORTS];
  logic              fl_a    [NUM_PORTS];
  logic              pf_a    [NUM_PORTS];
`ifdef MSC_STATUS_READ_EN
  logic [STAT_W-1:0] status_a [NUM_PORTS];
`endif

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    msc_port_ctrl #(
      .PAGE_W (PAGE_W),
      .DATA_W (DATA_W)
    ) u_port (
      .clk        (clk),
      .rst        (rst),
      .ctrl_we_i  (bus.wren & (bus.A == ADDR_W'(2 * i))),
      .page_we_i  (bus.wren & (bus.A == ADDR_W'(2 * i + 1))),
      .data_i     (bus.data),
      .req_i      (bus.port_req[i]),
      .ready_i    (bus.port_ready[i]),
      .page_o     (page_a[i]),
      .reset_o    (rst_a[i]),
      .flush_o    (fl_a[i]),
      .prefetch_o (pf_a[i])
`ifdef MSC_STATUS_READ_EN
      ,
      .status_o   (status_a[i])
`endif
    );
  end

  always_comb begin
    bus.page          = '0;
    bus.port_reset    = '0;
    bus.port_flush    = '0;
    bus.port_prefetch = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      bus.page[p*PAGE_W +: PAGE_W] = page_a[p];
      bus.port_reset[p]            = rst_a[p];
      bus.port_flush[p]            = fl_a[p];
      bus.port_prefetch[p]         = pf_a[p];
    end
  end

`ifdef MSC_STATUS_READ_EN
  always_comb begin
    bus.rdata = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (bus.A == ADDR_W'(2 * p))          bus.rdata = DATA_W'(status_a[p]);
      else if (bus.A == ADDR_W'(2 * p + 1)) bus.rdata = DATA_W'(page_a[p]);
    end
  end
`else
  assign bus.rdata = '0;
`endif

endmodule

// File: tb/tb_msc_multi.sv
// Directed self-checking bench for msc_multi (default 4 ports, 8-bit pages).
module tb_msc_multi;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  msc_multi_if #(.NUM_PORTS(4), .PAGE_W(8), .DATA_W(16)) bus ();

  msc_multi #(.NUM_PORTS(4), .PAGE_W(8), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.wren = 1'b1;
    bus.A    = a;
    bus.data = d;
    tick();
    bus.wren = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.wren       = 1'b0;
    bus.A          = '0;
    bus.data       = '0;
    bus.port_req   = '0;
    bus.port_ready = '1;
    tick();
    tick();
    chk("rst_port_reset", 32'(bus.port_reset), 32'hF);
    chk("rst_page", bus.page, 32'h0);
    chk("rst_flush", 32'(bus.port_flush), 32'h0);
    chk("rst_prefetch", 32'(bus.port_prefetch), 32'h0);

    // Release: one port_reset strobe on every idle port, then quiet.
    rst = 1'b0;
    #1;
    chk("rel_strobe", 32'(bus.port_reset), 32'hF);
    tick();
    chk("rel_after1", 32'(bus.port_reset), 32'h0);
    tick();
    chk("rel_after2", 32'(bus.port_reset), 32'h0);
`ifdef MSC_STATUS_READ_EN
    bus.A = 3'd0;
    #1;
    chk("rel_status0", 32'(bus.rdata), 32'h0);
`else
    bus.A = 3'd1;
    #1;
    chk("rdata_const0", 32'(bus.rdata), 32'h0);
`endif

    // Port 0: command ignored while disabled, then prefetch after enabling.
    wr(3'd0, 16'h0004);
    chk("pf_dis0", 32'(bus.port_prefetch), 32'h0);
    tick();
    chk("pf_dis1", 32'(bus.port_prefetch), 32'h0);
    wr(3'd0, 16'h0008);
    chk("pf_en_only", 32'(bus.port_prefetch), 32'h0);
    wr(3'd0, 16'h000C);
    chk("pf_strobe", 32'(bus.port_prefetch), 32'h1);
    tick();
    chk("pf_once", 32'(bus.port_prefetch), 32'h0);

    // Back-to-back writes: the re-set flag survives the issue edge.
    bus.wren = 1'b1;
    bus.A    = 3'd0;
    bus.data = 16'h000C;
    tick();
    chk("setwin_1", 32'(bus.port_prefetch), 32'h1);
    tick();
    bus.wren = 1'b0;
    chk("setwin_2", 32'(bus.port_prefetch), 32'h1);
    tick();
    chk("setwin_3", 32'(bus.port_prefetch), 32'h0);

    // Port 1: flush held while busy, issued on the falling edge of ready.
    wr(3'd2, 16'h0008);
    bus.port_req[1] = 1'b1;
    tick();
    wr(3'd2, 16'h000A);
    chk("fl_busy0", 32'(bus.port_flush), 32'h0);
    bus.port_req[1] = 1'b0;
    tick();
    chk("fl_busy1", 32'(bus.port_flush), 32'h0);
    bus.port_ready[1] = 1'b0;
    #1;
    chk("fl_strobe", 32'(bus.port_flush), 32'h2);
    tick();
    chk("fl_once", 32'(bus.port_flush), 32'h0);
    bus.port_ready[1] = 1'b1;
    tick();

    // Port 2: all commands pending while busy; reset wins and clears the rest.
    wr(3'd4, 16'h0008);
    bus.port_req[2] = 1'b1;
    tick();
    wr(3'd4, 16'h000F);
    chk("all_busy_rst", 32'(bus.port_reset), 32'h0);
    chk("all_busy_fl", 32'(bus.port_flush), 32'h0);
`ifdef MSC_STATUS_READ_EN
    bus.A = 3'd4;
    #1;
    chk("all_status_busy", 32'(bus.rdata), 32'h1F);
`endif
    bus.port_req[2]   = 1'b0;
    bus.port_ready[2] = 1'b0;
    #1;
    chk("all_rst_strobe", 32'(bus.port_reset), 32'h4);
    chk("all_no_fl", 32'(bus.port_flush), 32'h0);
    chk("all_no_pf", 32'(bus.port_prefetch), 32'h0);
    tick();
    chk("all_after_rst", 32'(bus.port_reset), 32'h0);
    chk("all_after_fl", 32'(bus.port_flush), 32'h0);
    chk("all_after_pf", 32'(bus.port_prefetch), 32'h0);
    tick();
    chk("all_later_fl", 32'(bus.port_flush), 32'h0);
    chk("all_later_pf", 32'(bus.port_prefetch), 32'h0);
`ifdef MSC_STATUS_READ_EN
    bus.A = 3'd4;
    #1;
    chk("all_status_idle", 32'(bus.rdata), 32'h01);
`endif
    bus.port_ready[2] = 1'b1;
    tick();

    // Port 3: page write gated by enable.
    wr(3'd6, 16'h0008);
    wr(3'd7, 16'h00A5);
    chk("page_load", bus.page, 32'hA500_0000);
    wr(3'd6, 16'h0000);
    wr(3'd7, 16'h0011);
    chk("page_locked", bus.page, 32'hA500_0000);
    bus.A = 3'd7;
    #1;
`ifdef MSC_STATUS_READ_EN
    chk("page_read", 32'(bus.rdata), 32'h00A5);
`else
    chk("page_read0", 32'(bus.rdata), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
